// File: rtl/resp_timer_pkg.sv
// Shared types and constants for the response-latency timer.
// The RESP_TIMER_TAG_EN build adds a sequence tag to each report.
package resp_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;
  localparam int          TAG_W        = 8;

endpackage

// File: rtl/resp_timer_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Reusable for any asynchronous target-side input.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s0;
  logic s1;
  logic s1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      s1_d <= 1'b0;
    end else begin
      s0   <= din;
      s1   <= s0;
      s1_d <= s1;
    end
  end

  assign rise = s1 & ~s1_d;

endmodule

// File: rtl/resp_timer.sv
// Counts cycles from a start pulse to the first rising edge of resp_in.
// Define RESP_TIMER_TAG_EN to put an 8-bit report sequence number in meas[31:24].
module resp_timer
  import resp_timer_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000,
  parameter logic [31:0] HOLDOFF = 32'd5_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        resp_in,
  output logic [31:0] meas,
  output logic        meas_valid,
  output logic        timeout,
  output logic        busy
);

  // Handshake: meas_valid is a single-cycle strobe with no back-pressure;
  // meas is valid in that cycle and holds until the next report.

  state_t      state;
  state_t      state_nx;
  logic [31:0] cnt;
  logic [31:0] cnt_nx;
  logic [31:0] hcnt;
  logic [31:0] hcnt_nx;
  logic        rise;
  logic        report;
  logic        report_to;
  logic [31:0] word;

  sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (resp_in),
    .rise (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 32'd0;
      hcnt  <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hcnt  <= hcnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hcnt_nx   = hcnt;
    report    = 1'b0;
    report_to = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_nx   = 32'd0;
          state_nx = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // An edge arriving on the timeout cycle still counts as a response.
        if (rise) begin
          report   = 1'b1;
          hcnt_nx  = 32'd0;
          state_nx = ST_HOLDOFF;
        end else if (cnt == TIMEOUT) begin
          report    = 1'b1;
          report_to = 1'b1;
          hcnt_nx   = 32'd0;
          state_nx  = ST_HOLDOFF;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      ST_HOLDOFF: begin
        if (hcnt + 32'd1 >= HOLDOFF) begin
          state_nx = ST_IDLE;
        end else begin
          hcnt_nx = hcnt + 32'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef RESP_TIMER_TAG_EN
  logic [TAG_W-1:0] seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= '0;
    end else if (report) begin
      seq <= seq + 1'b1;
    end
  end

  always_comb begin
    if (report_to) begin
      word = {seq, TIMEOUT_CODE[23:0]};
    end else if (cnt > 32'h00FF_FFFF) begin
      word = {seq, 24'hFF_FFFF};
    end else begin
      word = {seq, cnt[23:0]};
    end
  end
`else
  assign word = report_to ? TIMEOUT_CODE : cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      meas       <= 32'd0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= report;
      timeout    <= report_to;
      if (report) begin
        meas <= word;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_resp_timer.sv
// Directed bench for resp_timer: expected reports queued by the driver, checked by a monitor.
// Honours RESP_TIMER_TAG_EN when computing expected words.
module tb_resp_timer;

  localparam logic [31:0] TMO = 32'd100;
  localparam logic [31:0] HLD = 32'd50;

  logic        clk;
  logic        rst;
  logic        start;
  logic        resp_in;
  logic [31:0] meas;
  logic        meas_valid;
  logic        timeout;
  logic        busy;

  logic [32:0] exp_q[$];
  int          vectors;
  int          miscompares;
  logic [7:0]  tb_seq;

  resp_timer #(
    .TIMEOUT (TMO),
    .HOLDOFF (HLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp_in    (resp_in),
    .meas       (meas),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] c, input logic to);
    logic [31:0] w;
`ifdef RESP_TIMER_TAG_EN
    if (to) w = {tb_seq, 24'hFF_FFFF};
    else    w = {tb_seq, (c > 32'h00FF_FFFF) ? 24'hFF_FFFF : c[23:0]};
`else
    w = to ? 32'hFFFF_FFFF : c;
`endif
    exp_q.push_back({to, w});
    tb_seq = tb_seq + 8'd1;
  endtask

  // Leaves the caller 1ns after E0, the edge that samples start.
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: busy still %b after 400 cycles, required 0", busy);
    end
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    for (int i = 1; i <= 300 && k == 0; i++) begin
      @(posedge clk);
      #1;
      if (meas_valid) k = i;
    end
    if (k == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid: no meas_valid within 300 cycles");
    end
  endtask

  // d >= 0: resp_in rises just after E0+d, so rise is sampled at E0+d+3.
  task automatic run_meas(input int d, input logic [31:0] c, input logic to);
    push_exp(c, to);
    pulse_start();
    if (d >= 0) begin
      repeat (d) @(posedge clk);
      #1 resp_in = 1'b1;
    end
    wait_idle();
    resp_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (meas_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_report: meas=%h timeout=%b with nothing expected", meas, timeout);
        end else begin
          e = exp_q.pop_front();
          if ({timeout, meas} !== e) begin
            miscompares++;
            $display("FAIL report: got timeout=%b meas=%h expected timeout=%b meas=%h",
                     timeout, meas, e[32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vectors     = 0;
    miscompares = 0;
    tb_seq      = 8'd0;
    rst         = 1'b1;
    start       = 1'b0;
    resp_in     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_meas", meas, 32'd0);
    check("reset_meas_valid", {31'd0, meas_valid}, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_meas(10, 32'd12, 1'b0);
    run_meas(0, 32'd2, 1'b0);

    // Timeout: report edge is E0+TIMEOUT+1.
    push_exp(32'd0, 1'b1);
    pulse_start();
    wait_valid(k);
    check("timeout_latency", k, TMO + 32'd1);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;

    run_meas(98, 32'd100, 1'b0);
    run_meas(99, 32'd0, 1'b1);

    // Response line already high at start: only the later rising edge counts.
    resp_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    push_exp(32'd12, 1'b0);
    pulse_start();
    repeat (5) @(posedge clk);
    #1 resp_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 resp_in = 1'b1;
    wait_idle();
    resp_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Busy and holdoff: starts during COUNT and early HOLDOFF are dropped.
    check("busy_idle", {31'd0, busy}, 32'd0);
    push_exp(32'd12, 1'b0);
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 resp_in = 1'b1;
    wait_valid(k);
    resp_in = 1'b0;
    repeat (48) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_holdoff_49", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("holdoff_expired_start_ignored", {31'd0, busy}, 32'd0);
    push_exp(32'd12, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_51_accepted", {31'd0, busy}, 32'd1);
    repeat (10) @(posedge clk);
    #1 resp_in = 1'b1;
    wait_idle();
    resp_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-COUNT: no report, outputs back to reset values.
    pulse_start();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_meas", meas, 32'd0);
    check("rst_meas_valid", {31'd0, meas_valid}, 32'd0);
    rst    = 1'b0;
    tb_seq = 8'd0;
    repeat (3) @(posedge clk);
    #1 resp_in = 1'b1;
    repeat (150) @(posedge clk);
    #1 resp_in = 1'b0;
    check("rst_no_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;

    // 257 reports: tag walks 0..255 and wraps to 0.
    for (int i = 0; i < 257; i++) begin
      run_meas(i % 5, 32'(i % 5 + 2), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/resp_timer.md
# resp_timer

Measures the response latency of the attacked target: counts clock cycles from a `start` pulse to the first rising edge on the target's response line. Reports the count as a 32-bit word with a one-cycle valid strobe. Sits directly upstream of the 4-byte UART word transmitter: `meas` drives its `data_in`, and `meas_valid` drives its `en`. A post-report holdoff prevents a new word from arriving while the previous four bytes are still being shifted out, because the transmitter has no busy output.

## Interface
- `TIMEOUT`, default 32'd50_000_000: max cycles to wait for a response; legal range 1 … 32'hFFFF_FFFE.
- `HOLDOFF`, default 32'd5_000: cycles spent in HOLDOFF after each report; must be ≥ 4 UART frames plus 2 cycles.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a measurement when accepted.
- `resp_in`  in  1  asynchronous response line from the target.
- `meas`  out  32  measured cycle count, or the timeout code.
- `meas_valid`  out  1  one-cycle pulse; `meas` is valid in that cycle and holds until the next report.
- `timeout`  out  1  high together with `meas_valid` when the measurement timed out.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- `resp_in` passes through a 2-FF synchronizer, then a rising-edge detector: `rise = s1 & ~s1_d`.
- States: IDLE, COUNT, HOLDOFF.
- IDLE:
  - `start`=1 → `cnt` ← 0, go to COUNT.
  - `rise` is ignored in IDLE.
- COUNT:
  - `rise`=1 → `meas` ← `cnt`, `meas_valid` ← 1, go to HOLDOFF.
  - else if `cnt` == `TIMEOUT` → `meas` ← 32'hFFFF_FFFF, `meas_valid` ← 1, `timeout` ← 1, go to HOLDOFF.
  - else `cnt` ← `cnt` + 1.
- HOLDOFF: counts `HOLDOFF` cycles, then returns to IDLE.
- `start` is ignored in COUNT and HOLDOFF; it is not queued.
- A response only registers on a rising edge. If `resp_in` is already high when `start` arrives, the block waits for a low→high transition or times out.
- `rise` and `cnt` == `TIMEOUT` in the same cycle: the edge wins and a normal count is reported.
- `cnt` is 32 bits. The `TIMEOUT` range guarantees it never wraps and never collides with the timeout code.

## Timing
- Reset values: `meas`=0, `meas_valid`=0, `timeout`=0, `busy`=0, state IDLE, synchronizer and edge registers 0, `cnt`=0.
- Counting origin: the clock edge that samples `start`=1 is edge E0.
- If `rise` is sampled at edge E0+k, then `meas` = k−1.
- `meas` includes a fixed 2-cycle synchronizer offset, which the host subtracts.
- `meas_valid` and `timeout` are registered. They are high for exactly the one cycle following the reporting edge.
- `busy` rises the cycle after E0. It falls the cycle after HOLDOFF expires.
- Next-start acceptance: the earliest accepted `start` comes 1 + `HOLDOFF` cycles after `meas_valid`.
- Reset mid-operation: abort immediately, apply the reset values, and emit no `meas_valid`.

## Configuration
- Macro `RESP_TIMER_TAG_EN`.
- Defined:
  - `meas[31:24]` carries an 8-bit report sequence number: reset 0, increments after every report including timeouts, wraps 255→0.
  - `meas[23:0]` carries min(`cnt`, 24'hFFFFFF).
  - The timeout code is {seq, 24'hFFFFFF}.
  - The host uses the tag to detect dropped words.
- Undefined: the full 32-bit count, no sequence register.

## Structure
- Package `resp_timer_pkg`:
  - state encoding constants ST_IDLE / ST_COUNT / ST_HOLDOFF.
  - `TIMEOUT_CODE` (32'hFFFF_FFFF).
  - `TAG_W` (8).
- Sub-module `sync_edge`: 2-FF synchronizer plus rising-edge detector.
  - Ports: `clk`, `rst`, `din`, `rise`.
  - Reused by later target-side inputs.
- Top level: FSM, cycle counter, holdoff counter, output registers.

## Test plan
- Basic count: `start` at E0; `resp_in` driven high just after E0+10 → `meas_valid` pulse with `meas`=12 and `timeout`=0.
- Timeout:
  - Setup: `TIMEOUT`=100 with `resp_in` held low.
  - Expected: `meas_valid` in the cycle after E0+101, `meas`=32'hFFFF_FFFF, `timeout`=1.
- Edge ties with timeout: with `TIMEOUT`=20, place the edge so `rise` is sampled at E0+21 → `meas`=20, `timeout`=0.
- Busy/holdoff: `HOLDOFF`=50; `start` pulses during COUNT and at 49 cycles after `meas_valid` → both ignored; a `start` at 51 cycles → accepted.
- Level-high response: `resp_in` high before `start`, falls 5 cycles later, rises 5 cycles after that → reports that rising edge, not 0.
- Reset/tag:
  - Reset asserted mid-COUNT → no `meas_valid`, `busy`=0 next cycle.
  - With `RESP_TIMER_TAG_EN`, 257 reports → tag 0,1,…,255,0.
